text_overlay: RTL and testbench
===============================

# text_overlay

Sequencing controller for the 8x8 font ROM (`text_gen`): owns a 16-character message buffer and loads canned messages into it on request. It walks the VGA raster pixel stream, drives the ROM's `char_addr`/`row_addr` and selects the bitmap bit, producing a `text_on` overlay flag with a fixed 2-cycle latency. It sits between the VGA controller and the colour mapper, and the game FSM issues message loads to it.

## Interface
- `X0`, default 256: left edge of the text window, in pixels.
- `Y0`, default 224: top edge of the text window, in pixels.
- `SCALE_LOG2`, default 1: glyph magnification of 2^SCALE_LOG2 in both axes.
- `clk` input 1: the single design clock.
- `reset` input 1: synchronous, active-high.
- `drawX` input 10: current pixel column.
- `drawY` input 10: current pixel row.
- `pix_valid` input 1: high while in the visible (non-blanked) region.
- `msg_load` input 1: request to load a message; it is a level, accepted when `busy`=0.
- `msg_sel` input 2: message to load; sampled on the accept cycle.
- `busy` output 1: high while the buffer is being written.
- `char_addr` output 8: ASCII code to the font ROM.
- `row_addr` output 3: glyph row to the font ROM.
- `bitmap` input 8: font ROM row data, combinational from `char_addr`/`row_addr`.
- `text_on` output 1: high when the pixel is a lit glyph pixel.

## Operation
- Messages are left-justified and space-padded (0x20) to 16 characters.
  - 0: all spaces.
  - 1: "PRESS ANY KEY".
  - 2: "PRESS START".
  - 3: "STOP".
- Loader FSM has two states, IDLE and LOAD.
  - IDLE: if `msg_load` is high, latch `msg_sel`, clear the index to 0, go to LOAD, and set `busy` high from the next cycle.
  - LOAD: write `buf[idx]` = message char, one char per cycle. After writing idx=15, return to IDLE; `busy` is low the following cycle.
  - A load therefore keeps `busy` high for exactly 16 cycles.
- `msg_load` during LOAD is ignored, not queued. `msg_sel` changes during LOAD have no effect.
- Render pipeline uses 11-bit signed `dx = drawX - X0` and `dy = drawY - Y0`.
  - The pixel is in-window iff 0 ≤ dx < 128<<SCALE_LOG2 and 0 ≤ dy < 8<<SCALE_LOG2.
  - char index = dx >> (3+SCALE_LOG2)
  - glyph col = (dx >> SCALE_LOG2) & 7
  - glyph row = (dy >> SCALE_LOG2) & 7
- Stage 1 (registered) produces `char_addr` = `buf[char index]` (0x20 when out of window), `row_addr` = glyph row, the glyph col, and `win_ok` = in-window & `pix_valid` & !`busy`.
- Stage 2 (registered): `text_on` = `win_ok` & `bitmap[7 - glyph col]`.
- `text_on` is forced to 0 for any pixel sampled while `busy`=1, so partial messages are never displayed.

## Timing
- Reset values:
  - FSM = IDLE, idx = 0, `busy` = 0.
  - All 16 buffer entries = 0x20.
  - `char_addr` = 0x20, `row_addr` = 0, `text_on` = 0.
- Latency: `drawX`/`drawY`/`pix_valid` sampled at edge n appear as `char_addr`/`row_addr` after edge n+1 and as `text_on` after edge n+2. The VGA side must delay hsync/vsync by 2 to match.
- Throughput: one pixel per clock, no stalls.
- Reset asserted mid-LOAD aborts the load. The buffer returns to all spaces and `busy` goes low on the cycle after reset.
- Simultaneous `msg_load` and last LOAD write: the request is ignored; the FSM enters IDLE and accepts on the next cycle if `msg_load` is still high.
- Window edges:
  - dx = -1 and dx = 128<<SCALE_LOG2 both give `text_on` = 0.
  - The last char column (index 15, col 7) is rendered.
- Coordinates near 0 with X0 > `drawX` must not wrap into the window. This is why the comparison is done on signed 11-bit values.

## Structure
- Package `text_pkg` holds:
  - `TXT_NCHARS` = 16, `ASCII_SPACE` = 8'h20.
  - enum `msg_e` {MSG_BLANK, MSG_PRESS_ANY, MSG_PRESS_START, MSG_STOP}.
  - The message strings as `logic [7:0]` constant arrays.
- Sub-module `text_msg_rom`: combinational (`msg_sel`, idx[3:0]) -> ascii[7:0]. The loader FSM and render pipeline remain in `text_overlay`.
- The font ROM is instantiated outside and connected via the ports.

## Test plan
- Reset, then scan the whole window with `pix_valid`=1 -> `text_on` is never high and `char_addr` is always 0x20.
- Pulse `msg_load` with `msg_sel`=1 -> `busy` high exactly 16 cycles; after that, `drawX`=256, `drawY`=224 yields `char_addr`=0x50, `row_addr`=0 at n+1 and `text_on`=1 at n+2.
- Message 1 loaded, `drawX`=266, `drawY`=224 (P, col 5, bitmap 11111000) -> `text_on`=0; `drawY`=226 (row 1, 11001100) with `drawX`=256 -> 1.
- Load `msg_sel`=2, `drawX`=368, `drawY`=224 -> `char_addr`=0x54 ('T'); hold `msg_load` high during LOAD with `msg_sel`=3 -> content stays "PRESS START", then a second load starts after IDLE.
- Assert `reset` at LOAD cycle 5 -> `busy`=0 and the buffer is all 0x20; stream pixels at `drawX`=255 and `drawX`=512 (window edges), and at `pix_valid`=0 -> `text_on`=0.
- Stream pixels during `busy` over a lit glyph position -> `text_on`=0 throughout; the first pixel sampled after `busy` falls renders normally.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants, message-select encoding and canned message text for the text overlay.
// Constants only: no timing and no flow control.
package text_pkg;

  localparam int         TXT_NCHARS  = 16;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    MSG_BLANK,
    MSG_PRESS_ANY,
    MSG_PRESS_START,
    MSG_STOP
  } msg_e;

  // Left-justified, space-padded to the full buffer width.
  localparam logic [7:0] MSG_PRESS_ANY_TXT [TXT_NCHARS] = '{
    8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h41, 8'h4E,
    8'h59, 8'h20, 8'h4B, 8'h45, 8'h59, 8'h20, 8'h20, 8'h20
  };
  localparam logic [7:0] MSG_PRESS_START_TXT [TXT_NCHARS] = '{
    8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h53, 8'h54,
    8'h41, 8'h52, 8'h54, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20
  };
  localparam logic [7:0] MSG_STOP_TXT [TXT_NCHARS] = '{
    8'h53, 8'h54, 8'h4F, 8'h50, 8'h20, 8'h20, 8'h20, 8'h20,
    8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20
  };

  function automatic logic [7:0] msg_char(input msg_e sel, input logic [3:0] idx);
    logic [7:0] c;
    case (sel)
      MSG_PRESS_ANY:   c = MSG_PRESS_ANY_TXT[idx];
      MSG_PRESS_START: c = MSG_PRESS_START_TXT[idx];
      MSG_STOP:        c = MSG_STOP_TXT[idx];
      default:         c = ASCII_SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_overlay_msg_rom.sv
// Canned message lookup (message, char index) -> ASCII.
// Combinational, zero latency; no flow control.
module text_msg_rom
  import text_pkg::*;
(
  input  logic [1:0] msg_sel_i,
  input  logic [3:0] idx_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = msg_char(msg_e'(msg_sel_i), idx_i);

endmodule

// File: rtl/text_overlay.sv
// Message buffer + loader FSM + 2-stage raster pipeline driving an external 8x8 font ROM.
// Pixel -> text_on latency 2 cycles, one pixel per clock, never stalls; msg_load is a level accepted only when idle.
module text_overlay
  import text_pkg::*;
#(
  parameter int X0         = 256,
  parameter int Y0         = 224,
  parameter int SCALE_LOG2 = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] drawX,
  input  logic [9:0] drawY,
  input  logic       pix_valid,
  input  logic       msg_load,
  input  logic [1:0] msg_sel,
  output logic       busy,
  output logic [7:0] char_addr,
  output logic [2:0] row_addr,
  input  logic [7:0] bitmap,
  output logic       text_on
);

  typedef enum logic {ST_IDLE, ST_LOAD} state_e;

  localparam logic signed [10:0] X0_S  = 11'(X0);
  localparam logic signed [10:0] Y0_S  = 11'(Y0);
  localparam logic signed [10:0] WIN_W = 11'(128 << SCALE_LOG2);
  localparam logic signed [10:0] WIN_H = 11'(8 << SCALE_LOG2);

  state_e     state_q;
  logic [3:0] idx_q;
  msg_e       sel_q;
  logic       busy_q;
  logic [7:0] msg_buf_q [TXT_NCHARS];
  logic [7:0] rom_ascii;

  text_msg_rom u_msg_rom (
    .msg_sel_i (sel_q),
    .idx_i     (idx_q),
    .ascii_o   (rom_ascii)
  );

  // Loader: one buffer entry per cycle; requests seen while loading are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      sel_q   <= MSG_BLANK;
      busy_q  <= 1'b0;
      for (int i = 0; i < TXT_NCHARS; i++) msg_buf_q[i] <= ASCII_SPACE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (msg_load) begin
            state_q <= ST_LOAD;
            sel_q   <= msg_e'(msg_sel);
            idx_q   <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          msg_buf_q[idx_q] <= rom_ascii;
          idx_q            <= idx_q + 4'd1;
          if (idx_q == 4'(TXT_NCHARS - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Signed offsets keep pixels left of / above the window from wrapping into it.
  logic signed [10:0] dx, dy;
  logic               in_win;
  logic [3:0]         char_idx;
  logic [7:0]         char_d, char_q;
  logic [2:0]         row_d, row_q;
  logic [2:0]         col_d, col_q;
  logic               win_ok_d, win_ok_q;
  logic               text_on_d, text_on_q;

  assign dx       = $signed({1'b0, drawX}) - X0_S;
  assign dy       = $signed({1'b0, drawY}) - Y0_S;
  assign in_win   = !dx[10] && (dx < WIN_W) && !dy[10] && (dy < WIN_H);
  assign char_idx = dx[3+SCALE_LOG2 +: 4];
  assign col_d    = dx[SCALE_LOG2 +: 3];
  assign row_d    = dy[SCALE_LOG2 +: 3];
  assign char_d   = in_win ? msg_buf_q[char_idx] : ASCII_SPACE;
  assign win_ok_d = in_win & pix_valid & ~busy_q;

  // Font ROM answers combinationally from stage-1 outputs, so stage 2 picks its bit.
  assign text_on_d = win_ok_q & bitmap[3'd7 - col_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      char_q    <= ASCII_SPACE;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      win_ok_q  <= 1'b0;
      text_on_q <= 1'b0;
    end else begin
      char_q    <= char_d;
      row_q     <= row_d;
      col_q     <= col_d;
      win_ok_q  <= win_ok_d;
      text_on_q <= text_on_d;
    end
  end

  assign busy      = busy_q;
  assign char_addr = char_q;
  assign row_addr  = row_q;
  assign text_on   = text_on_q;

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay with a small stand-in font ROM; expected values are hand-computed.
module tb_text_overlay;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] drawX, drawY;
  logic       pix_valid, msg_load;
  logic [1:0] msg_sel;
  logic       busy;
  logic [7:0] char_addr;
  logic [2:0] row_addr;
  logic [7:0] bitmap;
  logic       text_on;

  text_overlay #(.X0(256), .Y0(224), .SCALE_LOG2(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .drawX     (drawX),
    .drawY     (drawY),
    .pix_valid (pix_valid),
    .msg_load  (msg_load),
    .msg_sel   (msg_sel),
    .busy      (busy),
    .char_addr (char_addr),
    .row_addr  (row_addr),
    .bitmap    (bitmap),
    .text_on   (text_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in font: 'P' rows 0/1 are F8/CC, others A5; space is blank; other glyphs {c[3:0]^row, 4'b1001}.
  function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
    if (c == 8'h20) return 8'h00;
    if (c == 8'h50) begin
      if (r == 3'd0) return 8'hF8;
      if (r == 3'd1) return 8'hCC;
      return 8'hA5;
    end
    return {c[3:0] ^ {1'b0, r}, 4'b1001};
  endfunction

  assign bitmap = font(char_addr, row_addr);

  typedef struct {
    int         d;
    int         x;
    int         y;
    bit         chk_ca;
    logic [7:0] ca;
    logic [2:0] row;
    bit         to;
  } exp_t;

  exp_t ca_q[$];
  exp_t to_q[$];
  exp_t me, mt;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: char/row one cycle after the pixel is driven, text_on two cycles after.
  always @(negedge clk) begin
    if (ca_q.size() > 0 && ca_q[0].d + 1 == cyc) begin
      me = ca_q.pop_front();
      if (me.chk_ca) begin
        check($sformatf("char_addr x=%0d y=%0d", me.x, me.y), 32'(char_addr), 32'(me.ca));
        check($sformatf("row_addr x=%0d y=%0d", me.x, me.y), 32'(row_addr), 32'(me.row));
      end
    end
    if (to_q.size() > 0 && to_q[0].d + 2 == cyc) begin
      mt = to_q.pop_front();
      check($sformatf("text_on x=%0d y=%0d", mt.x, mt.y), 32'(text_on), 32'(mt.to));
    end
  end

  // Called at a negedge; drives one pixel, queues its expectation, returns at the next negedge.
  task automatic pix(input int x, input int y, input bit v, input bit chk_ca,
                     input logic [7:0] ca, input logic [2:0] row, input bit to);
    exp_t e;
    drawX = 10'(x);
    drawY = 10'(y);
    pix_valid = v;
    e.d = cyc; e.x = x; e.y = y; e.chk_ca = chk_ca; e.ca = ca; e.row = row; e.to = to;
    ca_q.push_back(e);
    to_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel);
    msg_sel  = sel;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; drawX = '0; drawY = '0; pix_valid = 1'b0; msg_load = 1'b0; msg_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset char_addr", 32'(char_addr), 32'h20);
    check("reset row_addr", 32'(row_addr), 32'd0);
    check("reset text_on", 32'(text_on), 32'd0);

    // Blank buffer: the whole window stays dark and reads spaces.
    for (int y = 224; y < 240; y++)
      for (int x = 256; x < 512; x++)
        pix(x, y, 1'b1, 1'b1, 8'h20, 3'((y - 224) >> 1), 1'b0);

    // "PRESS ANY KEY"
    load(2'd1);
    busy_len(n);
    check("busy_len msg1", 32'(n), 32'd16);
    pix(256, 224, 1'b1, 1'b1, 8'h50, 3'd0, 1'b1);
    pix(258, 224, 1'b1, 1'b1, 8'h50, 3'd0, 1'b1);
    pix(266, 224, 1'b1, 1'b1, 8'h50, 3'd0, 1'b0);
    pix(256, 226, 1'b1, 1'b1, 8'h50, 3'd1, 1'b1);
    pix(256, 239, 1'b1, 1'b1, 8'h50, 3'd7, 1'b1);
    pix(256, 240, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(256, 223, 1'b1, 1'b1, 8'h20, 3'd7, 1'b0);
    pix(255, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(512, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(0,   224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(352, 224, 1'b1, 1'b1, 8'h41, 3'd0, 1'b0);
    pix(416, 224, 1'b1, 1'b1, 8'h4B, 3'd0, 1'b1);
    pix(462, 224, 1'b1, 1'b1, 8'h59, 3'd0, 1'b1);
    pix(510, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(511, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(256, 224, 1'b0, 1'b1, 8'h50, 3'd0, 1'b0);

    // "PRESS START" with msg_load held and msg_sel switched to 3 during the load.
    msg_sel  = 2'd2;
    msg_load = 1'b1;
    @(negedge clk);
    msg_sel = 2'd3;
    busy_len(n);
    check("busy_len msg2", 32'(n), 32'd16);
    pix(368, 224, 1'b1, 1'b1, 8'h54, 3'd0, 1'b0);
    check("reload busy", 32'(busy), 32'd1);
    msg_load = 1'b0;
    for (int i = 0; i < 16; i++)
      pix(260, 224, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    pix(260, 224, 1'b1, 1'b1, 8'h53, 3'd0, 1'b1);
    pix(272, 224, 1'b1, 1'b1, 8'h54, 3'd0, 1'b0);
    pix(288, 224, 1'b1, 1'b1, 8'h4F, 3'd0, 1'b1);
    pix(304, 224, 1'b1, 1'b1, 8'h50, 3'd0, 1'b1);
    pix(320, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);
    pix(368, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);

    // Reset during the fifth LOAD cycle aborts and clears the buffer.
    load(2'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort text_on", 32'(text_on), 32'd0);
    for (int i = 0; i < 16; i++)
      pix(256 + 16 * i, 224, 1'b1, 1'b1, 8'h20, 3'd0, 1'b0);

    load(2'd3);
    busy_len(n);
    check("busy_len after abort", 32'(n), 32'd16);
    pix(288, 224, 1'b1, 1'b1, 8'h4F, 3'd0, 1'b1);
    pix(256, 224, 1'b1, 1'b1, 8'h53, 3'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(ca_q.size() + to_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
